plan_logit: RTL and testbench

Pipelined fixed-point inverse of the PLAN sigmoid approximation: maps a probability-domain value y back to the pre-activation domain x. It reproduces the exact piecewise-linear inverse of the four PLAN segments, so that plan_logit(sigmoid(x)) ≈ x within truncation error. It sits after sigmoid-domain post-processing in the ShuffleNet datapath (e.g. score recalibration). It uses a full valid/ready handshake with backpressure, unlike the en-driven sigmoid.

---
 rtl/plan_pkg.sv | 53 +++++
 rtl/plan_pipe_slice.sv | 46 ++++
 rtl/plan_logit.sv | 141 ++++++++++++++
 tb/tb_plan_logit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/plan_pkg.sv
// Shared constants and types for the PLAN sigmoid family.
// Every constant is exact in Q.frac, so it is computed from the fractional width.
package plan_pkg;

  typedef enum logic [1:0] {
    SEG_A   = 2'd0,
    SEG_B   = 2'd1,
    SEG_C   = 2'd2,
    SEG_SAT = 2'd3
  } seg_e;

  // Left shifts that undo each segment's slope (1/4, 1/8, 1/32)
  localparam int unsigned SHIFT_A = 2;
  localparam int unsigned SHIFT_B = 3;
  localparam int unsigned SHIFT_C = 5;

  function automatic longint ONE(input int unsigned frac);
    return longint'(1) << frac;
  endfunction

  function automatic longint HALF(input int unsigned frac);
    return longint'(1) << (frac - 1);
  endfunction

  // 0.75 = 3/4
  function automatic longint BRK_075(input int unsigned frac);
    return longint'(3) << (frac - 2);
  endfunction

  // 0.921875 = 59/64
  function automatic longint BRK_0921875(input int unsigned frac);
    return longint'(59) << (frac - 6);
  endfunction

  function automatic longint OFS_05(input int unsigned frac);
    return longint'(1) << (frac - 1);
  endfunction

  // 0.625 = 5/8
  function automatic longint OFS_0625(input int unsigned frac);
    return longint'(5) << (frac - 3);
  endfunction

  // 0.84375 = 27/32
  function automatic longint OFS_084375(input int unsigned frac);
    return longint'(27) << (frac - 5);
  endfunction

  function automatic longint SAT_5(input int unsigned frac);
    return longint'(5) << frac;
  endfunction

endpackage

// File: rtl/plan_pipe_slice.sv
// Single valid/ready register slice. The payload loads only on an accepted
// transfer, so idle cycles never toggle the data register.
module plan_pipe_slice #(
  parameter int unsigned pWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [pWIDTH-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [pWIDTH-1:0] out_data
);

  logic              valid_q;
  logic [pWIDTH-1:0] data_q;

  // Empty, or draining this cycle
  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // Occupancy: refilled (or emptied) whenever the slice may move
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else if (in_ready) begin
      valid_q <= in_valid;
    end
  end

  // Payload: captured only on an accepted transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else if (in_valid && in_ready) begin
      data_q <= in_data;
    end
  end

  // A stalled output must keep presenting the same payload
  assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));

endmodule

// File: rtl/plan_logit.sv
// Pipelined inverse of the PLAN sigmoid: y (probability domain) -> x.
// Three stages: fold around 0.5, pick the segment and subtract its offset,
// then undo the slope with a shift and restore the sign.
module plan_logit
  import plan_pkg::*;
#(
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned pFRAC_NUM   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [pDATA_WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [pDATA_WIDTH-1:0] out_data
);

  localparam int unsigned W = pDATA_WIDTH;

  localparam logic signed [W-1:0] KOne    = W'(ONE(pFRAC_NUM));
  localparam logic signed [W-1:0] KHalf   = W'(HALF(pFRAC_NUM));
  localparam logic signed [W-1:0] KBrkB   = W'(BRK_075(pFRAC_NUM));
  localparam logic signed [W-1:0] KBrkC   = W'(BRK_0921875(pFRAC_NUM));
  localparam logic signed [W-1:0] KOfsA   = W'(OFS_05(pFRAC_NUM));
  localparam logic signed [W-1:0] KOfsB   = W'(OFS_0625(pFRAC_NUM));
  localparam logic signed [W-1:0] KOfsC   = W'(OFS_084375(pFRAC_NUM));
  localparam logic signed [W-1:0] KSat5   = W'(SAT_5(pFRAC_NUM));

  typedef struct packed {
    logic                neg;
    logic                sat;
    logic signed [W-1:0] m;
  } s1_t;

  typedef struct packed {
    logic                neg;
    seg_e                seg;
    logic [2:0]          shift;
    logic signed [W-1:0] d;
  } s2_t;

  s1_t                 s1_d, s1_q;
  s2_t                 s2_d, s2_q;
  logic signed [W-1:0] offset;
  logic signed [W-1:0] mag;
  logic [W-1:0]        s3_d;

  logic v1, v2;
  logic r0, r1, r2;

  // Stage 1: fold the lower half onto [0.5, 1) and flag saturation
  always_comb begin
    s1_d     = '0;
    s1_d.neg = $signed(in_data) < KHalf;
    s1_d.sat = in_data[W-1] || (in_data == '0) || ($signed(in_data) >= KOne);
    s1_d.m   = s1_d.neg ? (KOne - $signed(in_data)) : $signed(in_data);
  end

  // Stage 2: segment select. Exactly at 0.921875 the B branch is taken so the
  // break point maps to 2.375, the value segment B produces there going forward.
  always_comb begin
    s2_d       = '0;
    s2_d.neg   = s1_q.neg;
    offset     = KOfsA;
    s2_d.seg   = SEG_A;
    s2_d.shift = 3'(SHIFT_A);
    if (s1_q.sat) begin
      offset     = '0;
      s2_d.seg   = SEG_SAT;
      s2_d.shift = 3'd0;
    end else if ($signed(s1_q.m) > KBrkC) begin
      offset     = KOfsC;
      s2_d.seg   = SEG_C;
      s2_d.shift = 3'(SHIFT_C);
    end else if ($signed(s1_q.m) >= KBrkB) begin
      offset     = KOfsB;
      s2_d.seg   = SEG_B;
      s2_d.shift = 3'(SHIFT_B);
    end
    s2_d.d = $signed(s1_q.m) - offset;
  end

  // Stage 3: undo the slope exactly and restore the sign
  always_comb begin
    if (s2_q.seg == SEG_SAT) begin
      mag = KSat5;
    end else begin
      mag = $signed(s2_q.d) <<< s2_q.shift;
    end
    s3_d = s2_q.neg ? W'(-mag) : W'(mag);
  end

  // No sample is accepted while reset is held
  assign in_ready = r0 && !rst;

  plan_pipe_slice #(
    .pWIDTH($bits(s1_t))
  ) u_slice1 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (r0),
    .in_data  (s1_d),
    .out_valid(v1),
    .out_ready(r1),
    .out_data (s1_q)
  );

  plan_pipe_slice #(
    .pWIDTH($bits(s2_t))
  ) u_slice2 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (v1),
    .in_ready (r1),
    .in_data  (s2_d),
    .out_valid(v2),
    .out_ready(r2),
    .out_data (s2_q)
  );

  plan_pipe_slice #(
    .pWIDTH(W)
  ) u_slice3 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (v2),
    .in_ready (r2),
    .in_data  (s3_d),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  // The shifted magnitude stays within [0, 5.0] for every valid sample
  assert property (@(posedge clk) disable iff (rst)
    v2 |-> ((mag >= 0) && (mag <= KSat5)));

endmodule

// File: tb/tb_plan_logit.sv
// Scoreboard bench for plan_logit in Q16.16: the driver pushes expected results
// when a sample is accepted, a monitor pops and compares each output transfer.
module tb_plan_logit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  typedef struct {
    int exp;
    int tol;
    int acc;
    bit lat;
  } sb_t;

  sb_t sbq[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  pushed = 0;
  int  popped = 0;
  bit  saw_full = 0;
  bit  rt_on = 0;

  plan_logit #(
    .pDATA_WIDTH(32),
    .pFRAC_NUM  (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input bit ok, input string name, input longint got, input longint want);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Called at a negedge; returns at the negedge after the sample is accepted
  task automatic send(input logic [W-1:0] y, input int exp, input int tol, input bit lat);
    int  guard;
    bit  exp_rdy;
    sb_t e;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = y;
    forever begin
      #1;
      exp_rdy = !(((pushed - popped) >= 3) && !out_ready);
      chk(in_ready == exp_rdy, "in_ready", in_ready, exp_rdy);
      if (!in_ready) saw_full = 1'b1;
      if (in_ready) begin
        e.exp = exp;
        e.tol = tol;
        e.acc = cyc;
        e.lat = lat;
        sbq.push_back(e);
        pushed++;
        @(negedge clk);
        break;
      end
      guard++;
      if (guard > 200) begin
        chk(1'b0, "accept_timeout", guard, 200);
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic drain();
    int g;
    g        = 0;
    in_valid = 1'b0;
    while (sbq.size() != 0 && g < 300) begin
      @(negedge clk);
      g++;
    end
    #3;
    chk(sbq.size() == 0, "drain", sbq.size(), 0);
    @(negedge clk);
  endtask

  // Samples just after the negedge: what it sees is what transfers at the next posedge
  task automatic monitor();
    bit           stall_prev;
    logic [W-1:0] data_prev;
    sb_t          e;
    int           diff;
    stall_prev = 1'b0;
    data_prev  = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk(out_valid && (out_data == data_prev), "stall_hold", out_data, data_prev);
        end
        if (out_valid && out_ready) begin
          if (sbq.size() == 0) begin
            chk(1'b0, "unexpected_out", out_data, 0);
          end else begin
            e = sbq.pop_front();
            popped++;
            diff = $signed(out_data) - e.exp;
            if (diff < 0) diff = -diff;
            chk(diff <= e.tol, "sb_data", out_data, e.exp);
            if (e.lat) chk(cyc == e.acc + 3, "latency", cyc, e.acc + 3);
          end
        end
        stall_prev = out_valid && !out_ready;
        data_prev  = out_data;
      end
    end
  endtask

  // Forward PLAN sigmoid, Q16.16, truncating
  function automatic int plan_sig(input int x);
    int a;
    int y;
    a = (x < 0) ? -x : x;
    if (a >= 327680)      y = 65536;
    else if (a >= 155648) y = (a >>> 5) + 55296;
    else if (a >= 65536)  y = (a >>> 3) + 40960;
    else                  y = (a >>> 2) + 32768;
    return (x < 0) ? (65536 - y) : y;
  endfunction

  initial begin
    int x;
    int a;
    int ex;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
    chk(out_data == '0, "rst_out_data", out_data, 0);
    chk(in_ready == 1'b0, "rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back positive branch, latency and no-gap checks
    send(32'h0000_8000, 32'h0000_0000, 0, 1'b1);
    send(32'h0000_A000, 32'h0000_8000, 0, 1'b1);
    send(32'h0000_C000, 32'h0001_0000, 0, 1'b1);
    send(32'h0000_E000, 32'h0002_0000, 0, 1'b1);
    send(32'h0000_F000, 32'h0003_0000, 0, 1'b1);
    drain();

    // Symmetry, saturation and the 0.921875 break point
    send(32'h0000_4000, 32'hFFFF_0000, 0, 1'b0);
    send(32'h0000_2000, 32'hFFFE_0000, 0, 1'b0);
    send(32'h0001_0000, 32'h0005_0000, 0, 1'b0);
    send(32'h7FFF_FFFF, 32'h0005_0000, 0, 1'b0);
    send(32'h0000_0000, 32'hFFFB_0000, 0, 1'b0);
    send(32'h8000_0000, 32'hFFFB_0000, 0, 1'b0);
    send(32'h0000_EC00, 32'h0002_6000, 0, 1'b0);
    drain();

    // Backpressure: out_ready low for cycles 2..7 of the stream
    saw_full = 1'b0;
    fork
      begin
        send(32'h0000_8000, 32'h0000_0000, 0, 1'b0);
        send(32'h0000_A000, 32'h0000_8000, 0, 1'b0);
        send(32'h0000_C000, 32'h0001_0000, 0, 1'b0);
        send(32'h0000_E000, 32'h0002_0000, 0, 1'b0);
        send(32'h0000_F000, 32'h0003_0000, 0, 1'b0);
        send(32'h0000_4000, 32'hFFFF_0000, 0, 1'b0);
        in_valid = 1'b0;
      end
      begin
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        repeat (6) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();
    chk(saw_full == 1'b1, "bp_ready_fell", saw_full, 1);

    // Asynchronous reset with three samples in flight
    out_ready = 1'b0;
    send(32'h0000_A000, 32'h0000_8000, 0, 1'b0);
    send(32'h0000_C000, 32'h0001_0000, 0, 1'b0);
    send(32'h0000_E000, 32'h0002_0000, 0, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk(out_valid == 1'b0, "midrst_out_valid", out_valid, 0);
    chk(out_data == '0, "midrst_out_data", out_data, 0);
    chk(in_ready == 1'b0, "midrst_in_ready", in_ready, 0);
    sbq.delete();
    pushed    = 0;
    popped    = 0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send(32'h0000_C000, 32'h0001_0000, 0, 1'b1);
    drain();

    // Round trip through the forward model with random backpressure
    rt_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          do begin
            x = int'($urandom_range(0, 786432)) - 393216;
            a = (x < 0) ? -x : x;
          end while (a >= 155648 && a <= 163840);
          ex = (x > 327680) ? 327680 : ((x < -327680) ? -327680 : x);
          send(plan_sig(x), ex, 64, 1'b0);
        end
        in_valid = 1'b0;
        rt_on    = 1'b0;
      end
      begin
        while (rt_on) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
